// File: rtl/layer_link_pkg.sv
// layer_link_pkg: shared pixel-vector type, FSM states and frame sizing for the layer link bridge
package layer_link_pkg;
    localparam int CHANNEL_NUM = 128;
    localparam int DATA_WIDTH  = 16;
    typedef enum logic [1:0] {IDLE, SYNC, SEND, GAP} link_state_e;
    typedef logic signed [DATA_WIDTH-1:0] pixel_vec_t [CHANNEL_NUM-1:0];
    function automatic int frame_pixels(input int fm_width);
        return fm_width * fm_width;
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: pixel-vector FIFO with flush; a push in the flush cycle becomes the first entry
module pixel_fifo
    import layer_link_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  pixel_vec_t  din_i,
    output pixel_vec_t  dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    pixel_vec_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, wa;
    logic [AW:0] count_q, count_d;
    always_comb begin
        wa      = flush_i ? '0 : wr_q;
        wr_d    = wa + AW'(push_i);
        rd_d    = flush_i ? '0 : rd_q + AW'(pop_i);
        count_d = flush_i ? (AW+1)'(push_i) : count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wa] <= din_i;
    end
    assign dout_o  = mem_q[rd_q];
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
endmodule

// File: rtl/layer_link_fifo.sv
// layer_link_fifo: buffers a layer's pixel vectors and replays them frame-aligned with a programmable gap
module layer_link_fifo
    import layer_link_pkg::*;
#(
    parameter int FM_WIDTH_OUT    = 28,
    parameter int FIFO_DEPTH      = 32,
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int GAP_WIDTH       = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     vs_in,
    input  logic                     data_in_valid,
    input  pixel_vec_t               data_in,
    input  logic [GAP_WIDTH-1:0]     gap_cfg,
    input  logic                     hold,
    output logic                     verticle_sync,
    output logic                     data_out_valid,
    output pixel_vec_t               data_out,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [LOG2_FIFO_DEPTH:0] fill_level
);
    localparam int FRAME = frame_pixels(FM_WIDTH_OUT);
    localparam int CW    = $clog2(FRAME + 1);
    link_state_e state_q, state_d;
    logic pending_q, pending_d, vsync_q, vsync_d, valid_q, valid_d;
    logic done_q, done_d, ovf_q, ovf_d;
    logic [CW-1:0] pix_q, pix_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    pixel_vec_t dout_q, dout_d, fifo_dout;
    logic full, empty, push, pop, last, start;
    pixel_fifo #(.DEPTH(FIFO_DEPTH), .AW(LOG2_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (vs_in),
        .din_i   (data_in),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fill_level)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            vsync_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            pix_q     <= '0;
            gap_q     <= '0;
            dout_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            vsync_q   <= vsync_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            pix_q     <= pix_d;
            gap_q     <= gap_d;
            dout_q    <= dout_d;
        end
    end
    // SYNC may already pop, so the first pixel follows the sync pulse by one cycle
    always_comb begin
        state_d = state_q;
        if (vs_in) state_d = IDLE;
        else case (state_q)
            IDLE:       state_d = start ? SYNC : IDLE;
            SYNC, SEND: state_d = !pop ? SEND : last ? IDLE : (gap_cfg != '0) ? GAP : SEND;
            GAP:        state_d = (gap_q <= GAP_WIDTH'(1)) ? SEND : GAP;
            default:    state_d = IDLE;
        endcase
    end
    always_comb begin
        start     = state_q == IDLE && pending_q && !empty && !vs_in;
        pop       = (state_q == SYNC || state_q == SEND) && !empty && !hold && !vs_in;
        last      = pop && pix_q == CW'(FRAME - 1);
        push      = data_in_valid && (vs_in || !full || pop);
        pending_d = vs_in || (pending_q && !start);
        vsync_d   = start;
        valid_d   = pop;
        done_d    = last;
        ovf_d     = !vs_in && (ovf_q || (data_in_valid && full && !pop));
        pix_d     = (vs_in || last) ? '0 : pix_q + CW'(pop);
        gap_d     = vs_in ? '0 : (pop && !last) ? gap_cfg : (state_q == GAP) ? gap_q - GAP_WIDTH'(1) : gap_q;
        dout_d    = dout_q;
        if (pop) dout_d = fifo_dout;
    end
    assign verticle_sync  = vsync_q;
    assign data_out_valid = valid_q;
    assign data_out       = dout_q;
    assign frame_done     = done_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_layer_link_fifo.sv
// tb_layer_link_fifo: directed vector table plus hand sequences for hold, truncation, reset and full-FIFO cases
module tb_layer_link_fifo;
    import layer_link_pkg::*;
    localparam int FM = 4;
    localparam int DEPTH = 4;
    localparam int LD = 2;
    localparam int GW = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic vs_in = 1'b0;
    logic data_in_valid = 1'b0;
    logic hold = 1'b0;
    logic [GW-1:0] gap_cfg = '0;
    pixel_vec_t data_in, data_out;
    logic verticle_sync, data_out_valid, frame_done, overflow;
    logic [LD:0] fill_level;
    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    typedef struct {
        bit rstn, vs, dv;
        int din, gap;
        bit hold, chk, ev, evl;
        int ed;
        bit efd, eo;
        int ef;
    } vec_t;
    vec_t vq[$];
    always #5 clk = ~clk;
    layer_link_fifo #(.FM_WIDTH_OUT(FM), .FIFO_DEPTH(DEPTH), .LOG2_FIFO_DEPTH(LD), .GAP_WIDTH(GW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .vs_in          (vs_in),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .gap_cfg        (gap_cfg),
        .hold           (hold),
        .verticle_sync  (verticle_sync),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .fill_level     (fill_level)
    );
    task automatic add(input bit r, v, d, input int din, g, input bit h, c, ev, evl,
                       input int ed, input bit efd, eo, input int ef);
        vec_t t;
        t.rstn = r; t.vs = v; t.dv = d; t.din = din; t.gap = g; t.hold = h;
        t.chk = c; t.ev = ev; t.evl = evl; t.ed = ed; t.efd = efd; t.eo = eo; t.ef = ef;
        vq.push_back(t);
    endtask
    task automatic drive(input bit r, v, d, input int din, g, input bit h);
        @(posedge clk);
        #1;
        cyc_n++;
        rstn = r;
        vs_in = v;
        data_in_valid = d;
        gap_cfg = GW'(g);
        hold = h;
        for (int c = 0; c < CHANNEL_NUM; c++) data_in[c] = DATA_WIDTH'(din + c);
        @(negedge clk);
    endtask
    task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_n, act, exp);
        end
    endtask
    task automatic chk_dat(input int ed);
        chk("data_ch0", data_out[0], ed);
        chk("data_ch127", data_out[CHANNEL_NUM-1], ed == 0 ? 0 : ed + CHANNEL_NUM - 1);
    endtask
    task automatic chk_out(input bit ev, evl, input int ed, input bit efd, eo, input int ef);
        chk("verticle_sync", verticle_sync, ev);
        chk("data_out_valid", data_out_valid, evl);
        chk_dat(ed);
        chk("frame_done", frame_done, efd);
        chk("overflow", overflow, eo);
        chk("fill_level", fill_level, ef);
    endtask
    initial begin
        int vcy[10] = '{4, 7, 10, 13, 16, 19, 22, 25, 28, 99};
        int vval[10] = '{201, 202, 203, 204, 205, 206, 209, 212, 215, 0};
        int j, last;
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // full-rate frame: sync at 3, pixels 1..16 in cycles 4..19, frame_done with the last
        for (int k = 0; k <= 20; k++)
            add(1, k == 0, k >= 1 && k <= 16, k, 0, 0, 1, k == 3, k >= 4 && k <= 19,
                k < 4 ? 0 : k > 19 ? 16 : k - 3, k == 19, 0,
                k < 2 ? 0 : k == 2 ? 1 : k <= 17 ? 2 : k == 18 ? 1 : 0);
        // gap 2 with full-rate input: one pixel per 3 cycles, drops once full without a pop
        j = 0;
        last = 16;
        for (int k = 0; k <= 30; k++) begin
            automatic bit v = vcy[j] == k;
            if (v) begin
                last = vval[j];
                j++;
            end
            add(1, k == 0, k >= 1 && k <= 16, 200 + k, 2, 0, 1, k == 3, v, last, 0, k >= 8,
                k < 2 ? 0 : k == 2 ? 1 : k < 5 ? 2 : k == 5 ? 3 : k <= 18 ? 4 :
                k <= 21 ? 3 : k <= 24 ? 2 : k <= 27 ? 1 : 0);
        end
        foreach (vq[i]) begin
            drive(vq[i].rstn, vq[i].vs, vq[i].dv, vq[i].din, vq[i].gap, vq[i].hold);
            if (vq[i].chk) chk_out(vq[i].ev, vq[i].evl, vq[i].ed, vq[i].efd, vq[i].eo, vq[i].ef);
        end
        // hold for 10 cycles with the FIFO full
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 301, 0, 0); chk("s3_ovf_cleared", overflow, 0);
        drive(1, 0, 1, 302, 0, 0);
        drive(1, 0, 1, 303, 0, 0); chk("s3_vsync", verticle_sync, 1);
        drive(1, 0, 1, 304, 0, 1); chk("s3_first_valid", data_out_valid, 1); chk_dat(301);
        drive(1, 0, 1, 305, 0, 1);
        drive(1, 0, 1, 306, 0, 1); chk("s3_fill_full", fill_level, 4);
        drive(1, 0, 1, 307, 0, 1); chk("s3_ovf_set", overflow, 1);
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, 0, 0, 1);
            chk("s3_hold_valid", data_out_valid, 0);
            chk("s3_hold_fill", fill_level, 4);
        end
        drive(1, 0, 0, 0, 0, 0); chk("s3_release_valid", data_out_valid, 0);
        for (int p = 302; p <= 305; p++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("s3_resume_valid", data_out_valid, 1);
            chk_dat(p);
        end
        drive(1, 0, 0, 0, 0, 0); chk("s3_drained_valid", data_out_valid, 0); chk("s3_drained_fill", fill_level, 0);
        // frame truncated by vs_in after pixel 7; value 100 opens the new frame
        drive(1, 1, 0, 0, 0, 0);
        for (int p = 1; p <= 9; p++) begin
            drive(1, 0, 1, 400 + p, 0, 0);
            if (p >= 4) begin
                chk("s4_valid", data_out_valid, 1);
                chk_dat(400 + p - 3);
            end
        end
        drive(1, 1, 1, 100, 0, 0); chk("s4_seventh", data_out_valid, 1); chk_dat(407);
        drive(1, 0, 0, 0, 0, 0); chk_out(0, 0, 407, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0); chk("s4_resync", verticle_sync, 1); chk("s4_no_done", frame_done, 0);
        drive(1, 0, 0, 0, 0, 0); chk_out(0, 1, 100, 0, 0, 0);
        // reset in SEND with three pixels buffered
        drive(1, 0, 1, 501, 0, 1);
        drive(1, 0, 1, 502, 0, 1);
        drive(1, 0, 1, 503, 0, 1);
        drive(1, 0, 1, 504, 0, 0);
        drive(0, 0, 0, 0, 0, 0); chk("s5_pre_fill", fill_level, 3); chk("s5_pre_valid", data_out_valid, 1); chk_dat(501);
        drive(1, 0, 1, 601, 0, 0); chk_out(0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 602, 0, 0); chk("s5_buf_fill", fill_level, 1);
        drive(1, 0, 0, 0, 0, 0); chk("s5_buf_fill2", fill_level, 2); chk("s5_quiet", data_out_valid, 0);
        drive(1, 1, 1, 610, 0, 0); chk("s5_no_sync", verticle_sync, 0); chk("s5_quiet2", data_out_valid, 0);
        drive(1, 0, 0, 0, 0, 0); chk("s5_flush_fill", fill_level, 1); chk("s5_no_sync2", verticle_sync, 0);
        drive(1, 0, 0, 0, 0, 0); chk("s5_sync", verticle_sync, 1);
        drive(1, 0, 0, 0, 0, 0); chk("s5_first_valid", data_out_valid, 1); chk_dat(610);
        // simultaneous push and pop while full
        drive(1, 0, 1, 701, 0, 1);
        drive(1, 0, 1, 702, 0, 1);
        drive(1, 0, 1, 703, 0, 1);
        drive(1, 0, 1, 704, 0, 1);
        drive(1, 0, 1, 705, 0, 0); chk("s6_full", fill_level, 4);
        drive(1, 0, 0, 0, 0, 1); chk_out(0, 1, 701, 0, 0, 4);
        drive(1, 0, 0, 0, 0, 0); chk_out(0, 0, 701, 0, 0, 4);
        for (int p = 702; p <= 705; p++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("s6_valid", data_out_valid, 1);
            chk_dat(p);
        end
        drive(1, 0, 0, 0, 0, 0); chk("s6_empty", fill_level, 0); chk("s6_ovf", overflow, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
